// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit -- instruction fetch front end for a synchronous-read imem.
//
// Generates the byte address for an instruction memory with a registered
// read (1-cycle latency) and tracks the PC of the word that memory is
// presenting. A redirect retargets the fetch with no bubble. A stall replays
// the held word by re-reading if_pc. All addresses wrap modulo IMEM_BYTES.
//
// Handshake: if_valid is the producer's valid and ~stall is the consumer's
// ready. An instruction is consumed on a rising edge where if_valid=1 and
// stall=0. While stalled, if_pc and the memory word stay stable. if_valid
// never drops because of a stall.
//
// Parameters:
//   RESET_PC    first byte address fetched after reset
//   IMEM_BYTES  instruction memory size in bytes (power of two, >= 8)
//
// Ports:
//   clk              clock, rising edge
//   resetn           asynchronous active-low reset
//   stall            downstream cannot accept the presented instruction
//   redirect         taken branch/jump this cycle
//   redirect_target  byte address of the next instruction on redirect
//   imem_addr        combinational byte address to the instruction memory
//   if_pc            PC of the word the memory presents this cycle
//   if_valid         if_pc and the memory word are meaningful
//   fetch_count      instructions consumed (if_valid & ~stall edges)
//   fetch_fault      sticky misaligned-redirect trap flag
//   fault_addr       redirect_target that caused the trap
//   dbg_state_o      FSM state (0=BOOT, 1=RUN, 2=FAULT)
//
// Build option:
//   FETCH_MISALIGN_TRAP_EN  defined: a misaligned RUN redirect enters FAULT.
//                           undefined: target[1:0] is forced to 00, and FAULT
//                           is never entered.
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic [31:0] fetch_count,
  output logic        fetch_fault,
  output logic [31:0] fault_addr,
  output logic [1:0]  dbg_state_o
);

  localparam logic [31:0] ADDR_MASK = 32'(IMEM_BYTES - 1);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  function automatic logic [31:0] wrap(input logic [31:0] a);
    return a & ADDR_MASK;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] count_q, count_d;
  logic [31:0] tgt_eff;
  logic        misaligned;
  logic        fault_set;
  logic [31:0] imem_addr_c;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign tgt_eff    = redirect_target;
  assign misaligned = (redirect_target[1:0] != 2'b00);
`else
  // Word-align the target rather than trapping.
  assign tgt_eff    = redirect_target & ~32'h0000_0003;
  assign misaligned = 1'b0;
`endif

  assign fault_set = (state_q == ST_RUN) && redirect && misaligned;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    if_pc_d     = if_pc_q;
    if_valid_d  = if_valid_q;
    count_d     = count_q;
    imem_addr_c = pc_q;
    case (state_q)
      ST_BOOT: begin
        // The memory reads RESET_PC during this cycle, so the word is
        // ready when if_valid rises one edge later.
        imem_addr_c = wrap(RESET_PC);
        if_pc_d     = wrap(RESET_PC);
        pc_d        = wrap(RESET_PC + 32'd4);
        if_valid_d  = 1'b1;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        if (if_valid_q && !stall && !fault_set) begin
          count_d = count_q + 32'd1;
        end
        if (redirect) begin
          imem_addr_c = wrap(tgt_eff);
          if (fault_set) begin
            if_valid_d = 1'b0;
            state_d    = ST_FAULT;
          end else begin
            if_pc_d    = wrap(tgt_eff);
            pc_d       = wrap(tgt_eff + 32'd4);
            if_valid_d = 1'b1;
          end
        end else if (stall) begin
          // Re-read the held word so the memory output stays stable.
          imem_addr_c = if_pc_q;
        end else begin
          imem_addr_c = pc_q;
          if_pc_d     = pc_q;
          pc_d        = wrap(pc_q + 32'd4);
        end
      end
      ST_FAULT: begin
        imem_addr_c = wrap(fault_addr);
        if_valid_d  = 1'b0;
      end
      default: begin
        state_d    = ST_BOOT;
        if_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_BOOT;
      pc_q       <= wrap(RESET_PC);
      if_pc_q    <= 32'd0;
      if_valid_q <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      count_q    <= count_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fault_q;
  logic [31:0] fault_addr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fault_q      <= 1'b0;
      fault_addr_q <= 32'd0;
    end else if (fault_set) begin
      fault_q      <= 1'b1;
      fault_addr_q <= redirect_target;
    end
  end

  assign fetch_fault = fault_q;
  assign fault_addr  = fault_addr_q;
`else
  assign fetch_fault = 1'b0;
  assign fault_addr  = 32'd0;
`endif

  assign imem_addr   = imem_addr_c;
  assign if_pc       = if_pc_q;
  assign if_valid    = if_valid_q;
  assign fetch_count = count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit -- self-checking bench for fetch_unit.
// Includes a registered-read byte memory, a cycle-level reference model
// feeding an expected queue, and directed boundary checks.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          IMEM_BYTES = 1024;
  localparam logic [31:0] MASK       = 32'(IMEM_BYTES - 1);
  localparam int          EXP_W      = 100;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        resetn;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] if_pc;
  logic        if_valid;
  logic [31:0] fetch_count;
  logic        fetch_fault;
  logic [31:0] fault_addr;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .IMEM_BYTES(IMEM_BYTES)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .imem_addr      (imem_addr),
    .if_pc          (if_pc),
    .if_valid       (if_valid),
    .fetch_count    (fetch_count),
    .fetch_fault    (fetch_fault),
    .fault_addr     (fault_addr),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- instruction memory (registered read) ----------------
  logic [7:0]  mem [0:IMEM_BYTES-1];
  logic [31:0] imem_rdata;

  function automatic logic [31:0] read_word(input logic [31:0] a);
    int b;
    b = int'(a & MASK);
    return {mem[(b + 3) % IMEM_BYTES], mem[(b + 2) % IMEM_BYTES],
            mem[(b + 1) % IMEM_BYTES], mem[b]};
  endfunction

  always @(posedge clk) imem_rdata <= read_word(imem_addr);

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_state;
  logic [31:0] m_pc, m_if_pc, m_count, m_faddr;
  logic        m_valid, m_fault;

  function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
    return t;
`else
    return t & ~32'h3;
`endif
  endfunction

  function automatic logic is_mis(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
    return t[1:0] != 2'b00;
`else
    return (t[1:0] != 2'b00) && 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_pc    = RESET_PC & MASK;
    m_if_pc = 32'd0;
    m_valid = 1'b0;
    m_count = 32'd0;
    m_fault = 1'b0;
    m_faddr = 32'd0;
  endtask

  function automatic logic [31:0] model_addr(input logic st, input logic rd, input logic [31:0] t);
    case (m_state)
      0:       return RESET_PC & MASK;
      1:       return rd ? (eff_target(t) & MASK) : (st ? m_if_pc : m_pc);
      default: return m_faddr & MASK;
    endcase
  endfunction

  task automatic model_edge(input logic st, input logic rd, input logic [31:0] t);
    case (m_state)
      0: begin
        m_if_pc = RESET_PC & MASK;
        m_pc    = (RESET_PC + 32'd4) & MASK;
        m_valid = 1'b1;
        m_state = 1;
      end
      1: begin
        if (rd && is_mis(t)) begin
          m_state = 2;
          m_valid = 1'b0;
          m_fault = 1'b1;
          m_faddr = t;
        end else begin
          if (m_valid && !st) m_count = m_count + 32'd1;
          if (rd) begin
            m_if_pc = eff_target(t) & MASK;
            m_pc    = (eff_target(t) + 32'd4) & MASK;
            m_valid = 1'b1;
          end else if (!st) begin
            m_if_pc = m_pc;
            m_pc    = (m_pc + 32'd4) & MASK;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_out();
    logic [EXP_W-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_empty: got 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
      check("if_valid",    32'(if_valid),    32'(e[99]));
      check("fetch_fault", 32'(fetch_fault), 32'(e[98]));
      check("state",       32'(dbg_state),   32'(e[97:96]));
      check("if_pc",       if_pc,            e[95:64]);
      check("fetch_count", fetch_count,      e[63:32]);
      check("fault_addr",  fault_addr,       e[31:0]);
      if (e[99]) check("instr", imem_rdata, read_word(e[95:64]));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left on a falling edge; inputs change away from posedge.
  task automatic cycle(input logic st, input logic rd, input logic [31:0] t);
    stall           = st;
    redirect        = rd;
    redirect_target = t;
    #1;
    check("imem_addr", imem_addr, model_addr(st, rd, t));
    @(posedge clk);
    model_edge(st, rd, t);
    exp_q.push_back({m_valid, m_fault, 2'(m_state), m_if_pc, m_count, m_faddr});
    @(negedge clk);
    compare_out();
  endtask

  task automatic do_reset();
    resetn          = 1'b0;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'd0;
    #1;
    model_reset();
    exp_q.delete();
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // ---------------- main stimulus ----------------
  logic [31:0] hold_word;
  logic [31:0] cnt_frozen;
  logic        r_st, r_rd;
  logic [31:0] r_tgt;

  initial begin
    for (int i = 0; i < IMEM_BYTES; i++) mem[i] = 8'($urandom_range(0, 255));
    do_reset();
    check("rst_if_pc",      if_pc,              32'd0);
    check("rst_count",      fetch_count,        32'd0);
    check("rst_fault",      32'(fetch_fault),   32'd0);
    check("rst_fault_addr", fault_addr,         32'd0);

    // Boot and sequential fetch.
    check("boot_c0_valid", 32'(if_valid), 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    check("boot_pc0",   if_pc,          32'd0);
    check("boot_valid", 32'(if_valid),  32'd1);
    cycle(1'b0, 1'b0, 32'd0);
    check("seq_pc4", if_pc, 32'd4);
    cycle(1'b0, 1'b0, 32'd0);
    check("seq_pc8", if_pc, 32'd8);

    // Stall three cycles at if_pc=8.
    hold_word = imem_rdata;
    repeat (3) begin
      cycle(1'b1, 1'b0, 32'd0);
      check("stall_pc",    if_pc,       32'd8);
      check("stall_word",  imem_rdata,  hold_word);
      check("stall_count", fetch_count, 32'd2);
      check("stall_addr",  imem_addr,   32'd8);
    end
    cycle(1'b0, 1'b0, 32'd0);
    check("post_stall_pc", if_pc,       32'd12);
    check("count3",        fetch_count, 32'd3);

    // Redirect together with stall.
    cycle(1'b0, 1'b0, 32'd0);
    check("pc_0x10", if_pc, 32'h10);
    cycle(1'b1, 1'b1, 32'h40);
    check("redir_pc",    if_pc,         32'h40);
    check("redir_valid", 32'(if_valid), 32'd1);
    cycle(1'b0, 1'b0, 32'd0);
    check("redir_next", if_pc, 32'h44);

    // Random aligned traffic, targets span twice the memory to hit wrap.
    repeat (60) begin
      r_st  = ($urandom_range(0, 9) < 3);
      r_rd  = ($urandom_range(0, 9) == 0);
      r_tgt = 32'($urandom_range(0, 511)) << 2;
      cycle(r_st, r_rd, r_tgt);
    end

    // Wrap.
    cycle(1'b0, 1'b1, 32'd1012);
    cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    check("wrap_1020", if_pc, 32'd1020);
    cycle(1'b0, 1'b0, 32'd0);
    check("wrap_0", if_pc, 32'd0);
    cycle(1'b0, 1'b1, 32'h408);
    check("wrap_tgt", if_pc, 32'h8);

    // Misaligned redirect.
    cnt_frozen = fetch_count;
    cycle(1'b0, 1'b1, 32'h22);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_fault",  32'(fetch_fault), 32'd1);
    check("mis_faddr",  fault_addr,       32'h22);
    check("mis_valid",  32'(if_valid),    32'd0);
    check("mis_count",  fetch_count,      cnt_frozen);
    repeat (4) begin
      r_st  = 1'($urandom_range(0, 1));
      r_tgt = 32'($urandom_range(0, 255)) << 2;
      cycle(r_st, 1'b1, r_tgt);
      check("fault_valid", 32'(if_valid), 32'd0);
      check("fault_count", fetch_count,   cnt_frozen);
      check("fault_imem",  imem_addr,     32'h22);
    end
`else
    check("mis_align_pc", if_pc,            32'h20);
    check("mis_valid",    32'(if_valid),    32'd1);
    check("mis_nofault",  32'(fetch_fault), 32'd0);
    check("mis_count",    fetch_count,      cnt_frozen + 32'd1);
`endif

    // Asynchronous reset mid-cycle during a stall.
    do_reset();
    cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 32'd0);
    check("pre_async_valid", 32'(if_valid), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("async_valid", 32'(if_valid),  32'd0);
    check("async_count", fetch_count,    32'd0);
    check("async_state", 32'(dbg_state), 32'd0);
    model_reset();
    exp_q.delete();
    stall = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    cycle(1'b0, 1'b0, 32'd0);
    check("restart_pc0", if_pc, RESET_PC);
    cycle(1'b0, 1'b0, 32'd0);
    check("restart_pc4", if_pc, RESET_PC + 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first byte address fetched after reset.
REQ-002 SHALL have parameter IMEM_BYTES, default 1024, meaning the instruction-memory size in bytes (power of two, at least 8).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn, input, 1, the reset: asynchronous and active-low.
REQ-005 SHALL have port stall, input, 1, downstream cannot accept the presented instruction this cycle.
REQ-006 SHALL have port redirect, input, 1, a taken branch or jump this cycle.
REQ-007 SHALL have port redirect_target, input, 32, the byte address of the next instruction when redirect=1.
REQ-008 SHALL have port imem_addr, output, 32, the combinational byte address driven to the instruction memory (registered read, 1-cycle latency, little-endian byte lanes).
REQ-009 SHALL have port if_pc, output, 32, the PC of the instruction word the memory presents this cycle.
REQ-010 SHALL have port if_valid, output, 1, the presented instruction and if_pc are meaningful.
REQ-011 SHALL have port fetch_count, output, 32, the number of instructions consumed, defined as cycles with if_valid=1 and stall=0.
REQ-012 SHALL have port fetch_fault, output, 1, a misaligned redirect was trapped; sticky.
REQ-013 SHALL have port fault_addr, output, 32, the offending redirect_target.

Function
REQ-014 SHALL implement states BOOT, RUN and FAULT; reset enters BOOT.
REQ-015 SHALL, in BOOT: drive imem_addr=RESET_PC and if_valid=0, and ignore stall and redirect; at the next edge load if_pc=RESET_PC and pc_reg=RESET_PC+4, set if_valid=1, and enter RUN.
REQ-016 SHALL, in RUN, drive imem_addr with priority redirect > stall > sequential: redirect_target, else if_pc (replay the held word), else pc_reg.
REQ-017 SHALL, at a RUN edge with redirect=1, load if_pc=target and pc_reg=target+4 with if_valid=1, so a redirect costs zero bubbles.
REQ-018 SHALL, at a RUN edge with stall=1 and redirect=0, hold pc_reg, if_pc and if_valid; because the memory re-reads if_pc, the instruction output stays stable.
REQ-019 SHALL, at a RUN edge with no stall and no redirect, set if_pc=pc_reg and pc_reg=pc_reg+4.
REQ-020 SHALL wrap every address (imem_addr, pc_reg, if_pc) modulo IMEM_BYTES: for example IMEM_BYTES-4 plus 4 becomes 0, and a target of IMEM_BYTES+8 becomes 8.
REQ-021 SHALL increment fetch_count by 1 on each edge with if_valid=1 and stall=0 (redirect cycles included), wrapping at 2^32 with no saturation.
REQ-022 SHALL, in FAULT: hold if_valid=0 and fetch_fault=1, freeze pc_reg, if_pc and fetch_count, hold imem_addr=fault_addr, and leave FAULT only through reset.

Reset
REQ-023 SHALL, while resetn=0 and independent of clk: set pc_reg=RESET_PC, if_pc=0, if_valid=0, fetch_count=0, fetch_fault=0, fault_addr=0, state=BOOT.
REQ-024 SHALL, on reset asserted mid-stream (including during stall or FAULT), immediately drop if_valid; the next fetch after release is RESET_PC via BOOT.
REQ-025 SHALL tolerate the memory's synchronous reset, because BOOT guarantees the first if_valid=1 occurs one edge after memory read of RESET_PC.

Configuration
REQ-026 SHALL, with macro FETCH_MISALIGN_TRAP_EN defined: treat a RUN redirect with redirect_target[1:0]!=0 as a fault, so that edge enters FAULT, latches fault_addr=redirect_target, and does not count the cycle in fetch_count.
REQ-027 SHALL, without FETCH_MISALIGN_TRAP_EN: force redirect_target[1:0] to 00 before use, never enter FAULT, and tie fetch_fault=0 and fault_addr=0.

Verification
REQ-028 SHALL cover boot and sequential fetch: release reset with RESET_PC=0 and no stall -> if_valid=0 in cycle 0, then if_pc=0,4,8,12 on successive cycles, and fetch_count=3 after the third valid cycle.
REQ-029 SHALL cover stall: assert stall for 3 cycles while if_pc=8 -> if_pc stays 8, imem_addr=8, the instruction word is unchanged and fetch_count is frozen; after release if_pc=12.
REQ-030 SHALL cover redirect: redirect=1 with target 0x40 while if_pc=0x10, together with stall=1 -> next cycle if_pc=0x40 and if_valid=1, then if_pc=0x44.
REQ-031 SHALL cover wrap: with IMEM_BYTES=1024, sequentially reach if_pc=1020 -> next if_pc=0; a redirect to 0x408 -> if_pc=0x008.
REQ-032 SHALL cover misalignment: redirect to 0x22 -> with the macro, fetch_fault=1, fault_addr=0x22, if_valid=0 indefinitely; without the macro, if_pc=0x20.
REQ-033 SHALL cover asynchronous reset: assert resetn=0 mid-cycle during a stall -> if_valid falls before the next edge, and after release the fetch restarts at RESET_PC.
